// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Issues one instruction-memory read
//                per instruction, holds the returned word for decode, waits
//                for write-back, then advances or redirects the PC. A
//                misaligned redirect target parks the unit in a sticky error
//                state until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode stage
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        ifu_valid,
  input  logic        idu_ready,
  // write-back / next-PC
  input  logic        wb_done,
  input  logic        npc_sel,
  input  logic [31:0] npc,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fetch_err_q, fetch_err_d;

  // A redirect to a non word-aligned target cannot be fetched.
  logic w_misaligned;
  assign w_misaligned = npc_sel && (npc[1:0] != 2'b00);

  // State and datapath registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state logic: one fetch, one handshake, one write-back per instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_rvalid) state_d = S_VALID;
      S_VALID: if (idu_ready) state_d = S_EXEC;
      S_EXEC:  if (wb_done) state_d = w_misaligned ? S_ERR : S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: response only captured in FETCH, PC only moved in EXEC.
  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    if ((state_q == S_FETCH) && imem_rvalid) begin
      inst_d = imem_rdata;
    end
    if ((state_q == S_EXEC) && wb_done) begin
      if (w_misaligned) begin
        fetch_err_d = 1'b1;
      end else begin
        pc_d = npc_sel ? npc : (pc_q + 32'd4);
      end
    end
  end

  // Moore outputs decoded from the current state only.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    ifu_valid = (state_q == S_VALID);
    imem_addr = pc_q;
    pc        = pc_q;
    inst      = inst_q;
    fetch_err = fetch_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Self-checking bench for ifu_fetch: directed scenarios then
//                randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ifu_valid;
  logic        idu_ready = 1'b0;
  logic        wb_done   = 1'b0;
  logic        npc_sel   = 1'b0;
  logic [31:0] npc       = 32'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .pc         (pc),
    .ifu_valid  (ifu_valid),
    .idu_ready  (idu_ready),
    .wb_done    (wb_done),
    .npc_sel    (npc_sel),
    .npc        (npc),
    .fetch_err  (fetch_err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: which phase of the instruction life-cycle we are in,
  // plus the architectural pc / held instruction / sticky error.
  localparam int P_BOOT = 0, P_WAIT_MEM = 1, P_OFFER = 2, P_RETIRE = 3, P_DEAD = 4;
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_BOOT;
    m_pc    = RST_PC;
    m_inst  = 32'h0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    case (m_phase)
      P_BOOT:     m_phase = P_WAIT_MEM;
      P_WAIT_MEM: if (imem_rvalid) begin m_inst = imem_rdata; m_phase = P_OFFER; end
      P_OFFER:    if (idu_ready) m_phase = P_RETIRE;
      P_RETIRE: if (wb_done) begin
        if (npc_sel && (npc % 4 != 0)) begin
          m_err = 1'b1; m_phase = P_DEAD;
        end else begin
          m_pc = npc_sel ? npc : m_pc + 32'd4;
          m_phase = P_WAIT_MEM;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("imem_req",  imem_req,  m_phase == P_WAIT_MEM);
    chk("imem_addr", imem_addr, m_pc);
    chk("ifu_valid", ifu_valid, m_phase == P_OFFER);
    chk("inst",      inst,      m_inst);
    chk("pc",        pc,        m_pc);
    chk("fetch_err", fetch_err, m_err);
  endtask

  // Check on the falling edge, advance model at the rising edge, return 1ns later.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic wb, input logic sel, input logic [31:0] n);
    imem_rvalid = rv; imem_rdata = rd; idu_ready = rdy;
    wb_done = wb; npc_sel = sel; npc = n;
  endtask

  // Entered 1ns after a rising edge: pulse reset between edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_imem_req",  imem_req,  1'b0);
    chk("rst_ifu_valid", ifu_valid, 1'b0);
    chk("rst_pc",        pc,        RST_PC);
    chk("rst_inst",      inst,      32'h0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full instruction starting in FETCH; the VALID phase also sees stray
  // wb_done / imem_rvalid pulses which must have no effect.
  task automatic fetch_exec(input logic [31:0] word, input int lat,
                            input logic sel, input logic [31:0] target);
    for (int i = 1; i < lat; i++) begin drive(0, 32'h0, 0, 0, 0, 0); tick(); end
    drive(1, word, 0, 0, 0, 0); tick();
    drive(1, 32'hBAD0_BAD0, 0, 1, 1, 32'h0000_1234); tick();
    chk("valid_inst_hold", inst, word);
    drive(0, 32'h0, 1, 0, 0, 0); tick();
    drive(0, 32'h0, 0, 1, sel, target); tick();
    drive(0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("por_pc", pc, RST_PC);
    chk("por_imem_req", imem_req, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset release, memory answers in the third FETCH cycle.
    tick();                                   // IDLE
    drive(0, 32'h0, 0, 0, 0, 0); tick();      // FETCH 1
    chk("addr_held", imem_addr, RST_PC);
    tick();                                   // FETCH 2
    drive(1, 32'h0000_0413, 0, 0, 0, 0); tick(); // FETCH 3
    drive(0, 32'h0, 0, 0, 0, 0);
    chk("first_valid", ifu_valid, 1'b1);
    chk("first_inst",  inst, 32'h0000_0413);
    chk("first_pc",    pc,   RST_PC);

    // Decode stalls four cycles, accepts on the fifth.
    for (int i = 0; i < 4; i++) tick();
    drive(0, 32'h0, 1, 0, 0, 0); tick();
    chk("valid_drop", ifu_valid, 1'b0);
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0); tick();   // stray response in EXEC
    drive(1, 32'hDEAD_BEEF, 0, 1, 0, 0); tick();   // wb_done wins over rvalid
    drive(0, 32'h0, 0, 0, 0, 0);
    chk("seq_pc", pc, 32'h8000_0004);
    chk("exec_inst_kept", inst, 32'h0000_0413);

    fetch_exec(32'h0010_0093, 1, 1'b0, 32'h0);
    chk("seq_addr", imem_addr, 32'h8000_0008);
    fetch_exec(32'h0000_006F, 2, 1'b1, 32'h8000_0100);
    chk("redirect_addr", imem_addr, 32'h8000_0100);
    fetch_exec(32'h1111_1111, 1, 1'b1, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch_exec(32'h2222_2222, 3, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0000_0000);
    fetch_exec(32'h3333_3333, 1, 1'b1, 32'h8000_0100);
    fetch_exec(32'h4444_4444, 1, 1'b1, 32'h8000_0102);
    chk("err_flag", fetch_err, 1'b1);
    chk("err_pc", pc, 32'h8000_0100);
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      tick();
      chk("err_no_req", imem_req, 1'b0);
    end

    // Reset during an outstanding fetch; stray response while in IDLE.
    async_reset();
    drive(0, 32'h0, 0, 0, 0, 0); tick();      // IDLE
    tick();                                   // FETCH, request outstanding
    async_reset();
    drive(1, 32'hBADB_ADBA, 0, 0, 0, 0); tick(); // IDLE with stray rvalid
    drive(0, 32'h0, 0, 0, 0, 0);
    chk("refetch_addr", imem_addr, RST_PC);
    chk("stray_ignored", inst, 32'h0);
    chk("refetch_req", imem_req, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 2) == 0, $urandom, 1'($urandom),
            $urandom_range(0, 2) == 0, 1'($urandom), tgt);
      tick();
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Param RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  fetch address; equals pc.
REQ-006 imem_rvalid  in  1  memory response valid, one-cycle pulse.
REQ-007 imem_rdata  in  32  instruction word; sampled only with imem_rvalid.
REQ-008 inst  out  32  latched instruction to decode stage.
REQ-009 pc  out  32  address of inst.
REQ-010 ifu_valid  out  1  inst/pc valid for decode.
REQ-011 idu_ready  in  1  decode stage accepts inst this cycle.
REQ-012 wb_done  in  1  current instruction retired; next-PC inputs valid this cycle.
REQ-013 npc_sel  in  1  1 = redirect (jump/branch taken/ecall/mret), 0 = sequential.
REQ-014 npc  in  32  redirect target, used only when npc_sel=1.
REQ-015 fetch_err  out  1  sticky misaligned-target error.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, VALID, EXEC, ERR.
REQ-017 IDLE -> FETCH unconditionally next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc held stable until imem_rvalid; on imem_rvalid latch inst<=imem_rdata, go VALID.
REQ-019 imem_rvalid in any state other than FETCH SHALL be ignored (inst unchanged).
REQ-020 VALID: ifu_valid=1; inst and pc held stable while ifu_valid=1 && idu_ready=0.
REQ-021 Handshake: ifu_valid && idu_ready in same cycle -> EXEC next cycle; ifu_valid deasserts next cycle.
REQ-022 EXEC: ifu_valid=0, imem_req=0; wait for wb_done.
REQ-023 wb_done in EXEC: pc <= npc_sel ? npc : pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0); next state FETCH.
REQ-024 wb_done with npc_sel=1 and npc[1:0]!=0: pc unchanged, fetch_err<=1, next state ERR.
REQ-025 ERR: absorbing until reset; imem_req=0, ifu_valid=0, fetch_err=1.
REQ-026 wb_done outside EXEC SHALL be ignored; npc/npc_sel ignored without wb_done.
REQ-027 wb_done and imem_rvalid together in EXEC: only wb_done acts.
REQ-028 Minimum latency reset-release to first ifu_valid: 2 cycles + memory latency (IDLE, FETCH, rvalid same-cycle as FETCH entry earliest -> VALID).
REQ-029 Sequential throughput: one instruction per (FETCH + VALID + EXEC) visit; no prefetch, at most one outstanding request.
REQ-030 imem_req, ifu_valid are Moore outputs (decoded from state only).

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, pc=RESET_PC, inst=0, fetch_err=0, imem_req=0, ifu_valid=0, regardless of clock.
REQ-032 Reset asserted mid-FETCH drops outstanding request; a late imem_rvalid after reset release SHALL be ignored unless state is FETCH.
REQ-033 Reset deassertion: first edge enters IDLE-to-FETCH sequence per REQ-017.

Verification
REQ-034 Reset release, memory returns 32'h0000_0413 after 3 cycles -> imem_addr=32'h8000_0000 held 3 cycles, then ifu_valid=1, inst=32'h0000_0413, pc=32'h8000_0000.
REQ-035 idu_ready low 4 cycles in VALID -> ifu_valid, inst, pc stable 4 cycles; accepted on 5th; ifu_valid=0 next cycle.
REQ-036 wb_done npc_sel=0 at pc=32'h8000_0004 -> next imem_addr=32'h8000_0008; npc_sel=1 npc=32'h8000_0100 -> imem_addr=32'h8000_0100.
REQ-037 wb_done npc_sel=1 npc=32'h8000_0102 -> fetch_err=1, imem_req stays 0 for 10 cycles, pc unchanged.
REQ-038 rst pulsed mid-FETCH (asynchronous, between edges) -> outputs reset immediately; stray imem_rvalid in IDLE ignored; refetch from 32'h8000_0000.
REQ-039 pc=32'hFFFF_FFFC, wb_done npc_sel=0 -> pc=32'h0000_0000; wb_done/imem_rvalid pulses in VALID produce no state change.
